// File: rtl/request_unit_if.sv
// Handshake bundle between the control unit, the memories and the request sequencer.
// slave is the sequencer's view; master is the control/memory side.
interface request_unit_if #(
   parameter int CNT_W = 32
);
   logic             dREN;
   logic             dWEN;
   logic             halt;
   logic             ihit;
   logic             dhit;
   logic             imemREN;
   logic             dmemREN;
   logic             dmemWEN;
   logic             pcEN;
   logic             rfEN;
   logic             halted;
   logic [CNT_W-1:0] icount;
   logic [CNT_W-1:0] dcount;

   modport slave (
      input  dREN, dWEN, halt, ihit, dhit,
      output imemREN, dmemREN, dmemWEN, pcEN, rfEN, halted, icount, dcount
   );

   modport master (
      output dREN, dWEN, halt, ihit, dhit,
      input  imemREN, dmemREN, dmemWEN, pcEN, rfEN, halted, icount, dcount
   );
endinterface

// File: rtl/request_unit.sv
// Memory-request sequencer: gates instruction fetch against data accesses,
// produces the PC/register-file strobe, latches halt and counts retirements.
module request_unit #(
   parameter int CNT_W = 32
) (
   input  logic          CLK,
   input  logic          RST,
   request_unit_if.slave ruif
);
   typedef enum logic [1:0] {
      FETCH = 2'b00,
      MEM   = 2'b01,
      HALT  = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   logic             dmem_ren_r;
   logic             dmem_wen_r;
   logic             halted_r;
   logic [CNT_W-1:0] icount_r;
   logic [CNT_W-1:0] dcount_r;
   logic             imem_ren_s;
   logic             pc_en_s;
   logic             data_req_s;

   assign data_req_s = ruif.dREN | ruif.dWEN;

   // Same-cycle fetch request and PC strobe; both forced low while reset is held.
   always_comb begin
      imem_ren_s = 1'b0;
      pc_en_s    = 1'b0;
      if (RST) begin
         imem_ren_s = 1'b0;
         pc_en_s    = 1'b0;
      end else begin
         case (state_r)
            FETCH: begin
               imem_ren_s = 1'b1;
               pc_en_s    = ruif.ihit & ~ruif.halt & ~data_req_s;
            end
            MEM: begin
               imem_ren_s = 1'b0;
               pc_en_s    = ruif.dhit;
            end
            HALT: begin
               imem_ren_s = 1'b0;
               pc_en_s    = 1'b0;
            end
            default: begin
               imem_ren_s = 1'b0;
               pc_en_s    = 1'b0;
            end
         endcase
      end
   end

   // Sequencer state, latched data requests, sticky halt and debug counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r    <= FETCH;
         dmem_ren_r <= 1'b0;
         dmem_wen_r <= 1'b0;
         halted_r   <= 1'b0;
         icount_r   <= {CNT_W{1'b0}};
         dcount_r   <= {CNT_W{1'b0}};
      end else begin
         if (pc_en_s) begin
            icount_r <= icount_r + CNT_ONE;
         end
         case (state_r)
            FETCH: begin
               if (ruif.ihit) begin
                  if (ruif.halt) begin
                     state_r  <= HALT;
                     halted_r <= 1'b1;
                  end else if (data_req_s) begin
                     // A store takes priority when both request lines are set.
                     state_r    <= MEM;
                     dmem_wen_r <= ruif.dWEN;
                     dmem_ren_r <= ruif.dREN & ~ruif.dWEN;
                  end
               end
            end
            MEM: begin
               if (ruif.dhit) begin
                  state_r    <= FETCH;
                  dmem_ren_r <= 1'b0;
                  dmem_wen_r <= 1'b0;
                  dcount_r   <= dcount_r + CNT_ONE;
               end
            end
            HALT: begin
               halted_r <= 1'b1;
            end
            default: begin
               state_r    <= FETCH;
               dmem_ren_r <= 1'b0;
               dmem_wen_r <= 1'b0;
            end
         endcase
      end
   end

   assign ruif.imemREN = imem_ren_s;
   assign ruif.pcEN    = pc_en_s;
   assign ruif.rfEN    = pc_en_s;
   assign ruif.dmemREN = dmem_ren_r;
   assign ruif.dmemWEN = dmem_wen_r;
   assign ruif.halted  = halted_r;
   assign ruif.icount  = icount_r;
   assign ruif.dcount  = dcount_r;
endmodule

// File: doc/request_unit.md
# request_unit

Memory-request sequencer that sits between the control unit and the instruction/data memory ports. It consumes the control unit's `dREN`, `dWEN` and `halt` outputs, issues instruction and data requests, and decides when the PC may advance and the register file may write. It holds each data request until the memory acknowledges it and latches halt permanently. It also keeps retired-instruction and data-access counters for debug.

## Interface
Parameters:
- CNT_W, 32, width of the `icount` and `dcount` performance counters.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- dREN  in  1  control unit: the current instruction is a load.
- dWEN  in  1  control unit: the current instruction is a store.
- halt  in  1  control unit: the current instruction is a halt.
- ihit  in  1  instruction memory: the fetch completed this cycle.
- dhit  in  1  data memory: the data access completed this cycle.
- imemREN  out  1  instruction read request.
- dmemREN  out  1  data read request (registered).
- dmemWEN  out  1  data write request (registered).
- pcEN  out  1  PC advance strobe, one cycle wide.
- rfEN  out  1  register-file write qualifier; equals `pcEN`.
- halted  out  1  sticky halt indicator (registered).
- icount  out  CNT_W  number of retired instructions.
- dcount  out  CNT_W  number of completed data accesses.

## Operation
The FSM has three states: FETCH, MEM and HALT. The reset state is FETCH.

FETCH:
- `imemREN`=1. `dmemREN`=`dmemWEN`=0.
- `ihit` & `halt` -> go to HALT. `pcEN`=0.
- `ihit` & (`dREN`|`dWEN`) & !`halt` -> go to MEM.
  - Register `dmemWEN`<=`dWEN` and `dmemREN`<=`dREN` & !`dWEN`. If both inputs are set, the store wins.
  - `pcEN`=0.
- `ihit` & no data request & !`halt` -> `pcEN`=1 this cycle; stay in FETCH.
- `dhit` in FETCH is ignored.

MEM:
- `imemREN`=0. `dmemREN`/`dmemWEN` are held at their latched values.
- `dhit` -> `pcEN`=1 this cycle. Clear `dmemREN`/`dmemWEN` on the edge. Go to FETCH.
- `ihit` in MEM is ignored. There is no timeout; the block waits indefinitely for `dhit`.

HALT:
- All request outputs are 0. `pcEN`=0. `halted`=1.
- No exit except RST. `ihit`, `dhit` and all control inputs are ignored.

Counters:
- `icount` increments on every cycle with `pcEN`=1.
- `dcount` increments on every `dhit` accepted in MEM.
- Both counters wrap modulo 2^CNT_W with no saturation.

`rfEN` = `pcEN`. It is never asserted in HALT.

Reset, at any time including mid-MEM:
- State returns to FETCH immediately (asynchronous).
- `dmemREN`=`dmemWEN`=`halted`=0. `icount`=`dcount`=0.
- With RST high, the combinational outputs are forced as follows: `imemREN`=0, `pcEN`=0, `rfEN`=0.

## Timing
Combinational from the inputs in the same cycle:
- `pcEN` and `rfEN` follow `ihit` (FETCH) or `dhit` (MEM).

Registered:
- `dmemREN`/`dmemWEN` assert the cycle after the `ihit` edge and deassert on the edge where `dhit` is sampled.
- `halted` rises on the edge after `ihit` & `halt`.

Per-instruction timing:
- ALU instruction: one `pcEN` per `ihit`. Back-to-back `ihit` cycles give back-to-back retirements.
- Memory instruction: minimum 2 cycles, 1 cycle of `ihit` plus at least 1 cycle in MEM until `dhit`.
- `dhit` coincident with entry into MEM, i.e. `dhit` in the same cycle as the FETCH `ihit`, is ignored. The `dhit` is only accepted while the state is MEM.

`imemREN` deasserts during MEM. Instruction fetch must not race with the data access.

## Test plan
- Reset, then drive `ihit`=1 for 5 cycles with no requests -> `pcEN`=1 in each of those cycles. `icount`=5, `dcount`=0. `dmemREN`=`dmemWEN`=0 throughout.
- Load: `ihit`=1 with `dREN`=1 -> `pcEN`=0. Next cycle `dmemREN`=1 and `imemREN`=0. Hold `dhit`=0 for 3 cycles, then 1 -> `pcEN`=1 in the `dhit` cycle only. `dmemREN`=0 on the following cycle. `dcount`=1.
- Store with `dREN`=`dWEN`=1 -> only `dmemWEN`=1 in MEM. `dhit` returns to FETCH. `icount` increments by 1.
- Halt: `ihit`=1 with `halt`=1 -> `halted`=1 on the next cycle. Then pulse `ihit`/`dhit` for 10 cycles -> `pcEN`, `imemREN` and the counters stay frozen.
- Assert RST mid-MEM, with `dmemWEN`=1 and the counters nonzero -> all outputs clear immediately. After RST release, `imemREN`=1 and the state is FETCH.
- Preload `icount`=2^CNT_W-1 (use CNT_W=4 and 15 retirements) -> the next `pcEN` wraps `icount` to 0.
